// File: rtl/audio_out_serializer_if.sv
// Handshake bundle between the audio-out drain logic and its surroundings:
// run/clear controls, clock-generator strobes, both FIFO read ports and the
// DAC-side outputs.
interface audio_out_serializer_if #(
  parameter int AUDIO_DATA_WIDTH = 16
);
  logic                        enable;
  logic                        clear_underflow;
  logic                        bit_clk_falling_edge;
  logic                        left_right_clk_rising_edge;
  logic                        left_right_clk_falling_edge;
  logic                        left_channel_fifo_is_empty;
  logic [AUDIO_DATA_WIDTH-1:0] left_channel_read_data;
  logic                        left_channel_read_en;
  logic                        right_channel_fifo_is_empty;
  logic [AUDIO_DATA_WIDTH-1:0] right_channel_read_data;
  logic                        right_channel_read_en;
  logic                        serial_audio_out_data;
  logic                        underflow;

  // Serializer side.
  modport slave (
    input  enable, clear_underflow,
    input  bit_clk_falling_edge, left_right_clk_rising_edge, left_right_clk_falling_edge,
    input  left_channel_fifo_is_empty, left_channel_read_data,
    input  right_channel_fifo_is_empty, right_channel_read_data,
    output left_channel_read_en, right_channel_read_en,
    output serial_audio_out_data, underflow
  );

  // Environment side: FIFOs, clock generator and control.
  modport master (
    output enable, clear_underflow,
    output bit_clk_falling_edge, left_right_clk_rising_edge, left_right_clk_falling_edge,
    output left_channel_fifo_is_empty, left_channel_read_data,
    output right_channel_fifo_is_empty, right_channel_read_data,
    input  left_channel_read_en, right_channel_read_en,
    input  serial_audio_out_data, underflow
  );
endinterface

// File: rtl/audio_out_serializer.sv
// I2S drain for the audio-out path: pops one word per LR frame from the
// left/right show-ahead FIFOs and shifts it MSB-first onto DACDAT on BCLK
// falling strobes, padding with zeros until the next LR strobe.
module audio_out_serializer #(
  parameter int AUDIO_DATA_WIDTH = 16,
  parameter int COUNTER_WIDTH    = 5
) (
  input logic                   clk,
  input logic                   reset,
  audio_out_serializer_if.slave bus
);

  localparam int W = AUDIO_DATA_WIDTH;
  localparam logic [COUNTER_WIDTH-1:0] W_COUNT = COUNTER_WIDTH'(AUDIO_DATA_WIDTH);

  typedef enum logic [1:0] {
    WAIT_SYNC,
    LEFT,
    RIGHT
  } state_t;

  state_t                   state;
  state_t                   next_state;
  logic                     left_load;
  logic                     right_load;
  logic                     load;
  logic                     load_empty;
  logic                     shift;
  logic [W-1:0]             shift_reg;
  logic [COUNTER_WIDTH-1:0] bit_count;
  logic                     out_q;
  logic                     underflow_q;

  // Frame state register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (reset) state <= WAIT_SYNC;
    else       state <= next_state;
  end

  // Next frame and which channel (if any) loads this cycle.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves
    // one unassigned, which would infer a latch.
    next_state = state;
    left_load  = 1'b0;
    right_load = 1'b0;
    if (!bus.enable) begin
      next_state = WAIT_SYNC;
    end else begin
      case (state)
        WAIT_SYNC: if (bus.left_right_clk_falling_edge) begin
          next_state = LEFT;
          left_load  = 1'b1;
        end
        LEFT: if (bus.left_right_clk_rising_edge) begin
          next_state = RIGHT;
          right_load = 1'b1;
        end
        RIGHT: if (bus.left_right_clk_falling_edge) begin
          next_state = LEFT;
          left_load  = 1'b1;
        end
        default: next_state = WAIT_SYNC;
      endcase
    end
  end

  assign load       = left_load | right_load;
  assign load_empty = left_load ? bus.left_channel_fifo_is_empty
                                : bus.right_channel_fifo_is_empty;

  // Pops are combinational so the show-ahead head word is captured in the
  // same cycle; reset gates them so no pop escapes while reset is asserted.
  assign bus.left_channel_read_en  = left_load  & ~bus.left_channel_fifo_is_empty  & ~reset;
  assign bus.right_channel_read_en = right_load & ~bus.right_channel_fifo_is_empty & ~reset;

  // A coincident LR strobe suppresses the shift: this is the I2S one-bit delay.
  assign shift = bus.bit_clk_falling_edge
               & ~bus.left_right_clk_rising_edge
               & ~bus.left_right_clk_falling_edge
               & (state != WAIT_SYNC);

  // Word load, MSB-first shifting and zero padding of DACDAT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      bit_count <= '0;
      out_q     <= 1'b0;
    end else if (!bus.enable) begin
      out_q <= 1'b0;
    end else if (load) begin
      if (load_empty)     shift_reg <= '0;
      else if (left_load) shift_reg <= bus.left_channel_read_data;
      else                shift_reg <= bus.right_channel_read_data;
      bit_count <= '0;
    end else if (shift) begin
      if (bit_count < W_COUNT) begin
        out_q     <= shift_reg[W-1];
        shift_reg <= {shift_reg[W-2:0], 1'b0};
        bit_count <= bit_count + COUNTER_WIDTH'(1);
      end else begin
        out_q <= 1'b0;
      end
    end
  end

  // Sticky underflow: set on an empty FIFO at frame load, set beats clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) underflow_q <= 1'b0;
    else       underflow_q <= (underflow_q & ~bus.clear_underflow) | (load & load_empty);
  end

  assign bus.serial_audio_out_data = out_q;
  assign bus.underflow             = underflow_q;

endmodule

// File: tb/tb_audio_out_serializer.sv
// Self-checking bench for audio_out_serializer: directed I2S scenarios plus
// randomized frames, checked against a frame-level model built on word
// queues and an expected-bit queue.
module tb_audio_out_serializer;

  localparam int W = 16;

  logic clk;
  logic reset;

  audio_out_serializer_if #(.AUDIO_DATA_WIDTH(W)) bus ();

  audio_out_serializer #(.AUDIO_DATA_WIDTH(W), .COUNTER_WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: FIFO contents, framing, expected bits of the current frame.
  logic [W-1:0] lq[$];
  logic [W-1:0] rq[$];
  bit           synced;
  bit           cur_right;
  bit           m_out;
  bit           m_und;
  bit           exp_bits[$];
  logic [31:0]  col;
  int           l_pops;
  int           r_pops;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    synced    = 0;
    cur_right = 0;
    m_out     = 0;
    m_und     = 0;
    exp_bits.delete();
    col       = '0;
  endtask

  task automatic drive_fifo();
    bus.left_channel_fifo_is_empty  = (lq.size() == 0);
    bus.left_channel_read_data      = (lq.size() != 0) ? lq[0] : W'($urandom);
    bus.right_channel_fifo_is_empty = (rq.size() == 0);
    bus.right_channel_read_data     = (rq.size() != 0) ? rq[0] : W'($urandom);
  endtask

  // One clock cycle with the given strobes; enable/clear are left as set.
  task automatic step(input bit bf, input bit lrr, input bit lrf);
    bit           l_load;
    bit           r_load;
    bit           set_u;
    logic [W-1:0] word;
    bus.bit_clk_falling_edge        = bf;
    bus.left_right_clk_rising_edge  = lrr;
    bus.left_right_clk_falling_edge = lrf;
    drive_fifo();
    l_load = bus.enable && lrf && (!synced || cur_right);
    r_load = bus.enable && lrr && synced && !cur_right;
    @(negedge clk);
    check("left_read_en",  32'(bus.left_channel_read_en),  32'(l_load && lq.size() != 0));
    check("right_read_en", 32'(bus.right_channel_read_en), 32'(r_load && rq.size() != 0));
    if (bus.left_channel_read_en)  l_pops++;
    if (bus.right_channel_read_en) r_pops++;
    @(posedge clk);
    #1;
    set_u = 0;
    if (!bus.enable) begin
      synced = 0;
      m_out  = 0;
    end else if (l_load || r_load) begin
      word = '0;
      if (l_load) begin
        if (lq.size() != 0) word = lq.pop_front();
        else                set_u = 1;
      end else begin
        if (rq.size() != 0) word = rq.pop_front();
        else                set_u = 1;
      end
      exp_bits.delete();
      for (int i = W - 1; i >= 0; i--) exp_bits.push_back(word[i]);
      synced    = 1;
      cur_right = r_load;
      col       = '0;
    end else if (bf && !lrr && !lrf && synced) begin
      m_out = (exp_bits.size() != 0) ? exp_bits.pop_front() : 1'b0;
      col   = {col[30:0], bus.serial_audio_out_data};
    end
    m_und = (m_und && !bus.clear_underflow) || set_u;
    check("dacdat",    32'(bus.serial_audio_out_data), 32'(m_out));
    check("underflow", 32'(bus.underflow),             32'(m_und));
  endtask

  task automatic bclks(input int n);
    for (int k = 0; k < n; k++) begin
      step(1, 0, 0);
      step(0, 0, 0);
    end
  endtask

  task automatic frame(input bit rise, input bit coincide, input int nb);
    step(coincide, rise, !rise);
    bclks(nb);
  endtask

  int lp;
  int rp;
  bit rise;
  int nb;

  initial begin
    reset                           = 1'b1;
    bus.enable                      = 1'b0;
    bus.clear_underflow             = 1'b0;
    bus.bit_clk_falling_edge        = 1'b0;
    bus.left_right_clk_rising_edge  = 1'b0;
    bus.left_right_clk_falling_edge = 1'b1;
    l_pops = 0;
    r_pops = 0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      lq.push_back(16'hA5F0);
      rq.push_back(16'h0F0F);
    end
    drive_fifo();

    // Reset state, with a load-looking strobe present.
    repeat (2) @(posedge clk);
    #1;
    bus.enable = 1'b1;
    #1;
    check("reset_dacdat",    32'(bus.serial_audio_out_data), 32'd0);
    check("reset_underflow", 32'(bus.underflow),             32'd0);
    check("reset_left_en",   32'(bus.left_channel_read_en),  32'd0);
    bus.left_right_clk_falling_edge = 1'b0;
    reset = 1'b0;

    // Rise strobe before sync is ignored; then four stereo frames.
    frame(1, 0, 4);
    for (int f = 0; f < 4; f++) begin
      frame(0, 0, 32);
      if (f == 0) check("left_frame_bits", col, 32'hA5F0_0000);
      frame(1, 0, (f == 3) ? 16 : 32);
      if (f == 0) check("right_frame_bits", col, 32'h0F0F_0000);
    end
    check("left_pops",  32'(l_pops), 32'd4);
    check("right_pops", 32'(r_pops), 32'd4);

    // Coincident LR and BCLK strobes: out holds, MSB on the next BCLK.
    lq.push_back(16'hA5F0);
    step(1, 0, 1);
    check("hold_on_coincide", 32'(bus.serial_audio_out_data), 32'd1);
    step(1, 0, 0);
    check("msb_after_coincide", 32'(bus.serial_audio_out_data), 32'd1);
    step(0, 0, 0);
    bclks(31);
    check("coincide_bits", col, 32'hA5F0_0000);

    // Right FIFO empty at rise: zeros, underflow, no pop; then clear.
    rp = r_pops;
    frame(1, 0, 16);
    check("underrun_bits", col, 32'd0);
    check("underrun_flag", 32'(bus.underflow), 32'd1);
    check("underrun_no_pop", 32'(r_pops), 32'(rp));
    bus.clear_underflow = 1'b1;
    step(0, 0, 0);
    bus.clear_underflow = 1'b0;
    check("underflow_cleared", 32'(bus.underflow), 32'd0);
    lq.push_back(16'h5A5A);
    frame(0, 0, 16);
    bus.clear_underflow = 1'b1;
    step(0, 1, 0);
    bus.clear_underflow = 1'b0;
    check("set_beats_clear", 32'(bus.underflow), 32'd1);
    bclks(16);

    // Disable after 5 bits of a left frame, re-enable on a rise strobe.
    lq.push_back(16'hF800);
    lq.push_back(16'h9876);
    step(0, 0, 1);
    bclks(5);
    check("five_bits_out", 32'(bus.serial_audio_out_data), 32'd1);
    bus.enable = 1'b0;
    lp = l_pops;
    rp = r_pops;
    step(1, 0, 0);
    check("disable_out", 32'(bus.serial_audio_out_data), 32'd0);
    bclks(3);
    bus.enable = 1'b1;
    rq.push_back(16'hE234);
    frame(1, 0, 8);
    check("rise_after_enable_ignored", 32'(r_pops), 32'(rp));
    frame(0, 0, 32);
    check("resume_left_word", col, 32'h9876_0000);
    check("resume_left_pop", 32'(l_pops), 32'(lp + 1));

    // Async reset mid-shift, with a would-be pop strobe present.
    lq.push_back(16'h1111);
    step(0, 1, 0);
    bclks(3);
    check("before_reset_out", 32'(bus.serial_audio_out_data), 32'd1);
    #2;
    bus.left_right_clk_falling_edge = 1'b1;
    drive_fifo();
    reset = 1'b1;
    #1;
    check("async_reset_dacdat",    32'(bus.serial_audio_out_data), 32'd0);
    check("async_reset_underflow", 32'(bus.underflow),             32'd0);
    check("async_reset_left_en",   32'(bus.left_channel_read_en),  32'd0);
    bus.left_right_clk_falling_edge = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    lp = l_pops;
    frame(1, 0, 4);
    check("post_reset_waits", 32'(l_pops + r_pops), 32'(lp + rp + 1));

    // Randomized frames: lengths, coincidence, underruns, clears, enable drops.
    rise = 0;
    for (int f = 0; f < 150; f++) begin
      if ($urandom_range(0, 3) != 0 && lq.size() < 4) lq.push_back(W'($urandom));
      if ($urandom_range(0, 3) != 0 && rq.size() < 4) rq.push_back(W'($urandom));
      bus.enable          = ($urandom_range(0, 11) != 0);
      bus.clear_underflow = ($urandom_range(0, 7) == 0);
      step(1'($urandom_range(0, 1)), rise, !rise);
      bus.enable          = 1'b1;
      bus.clear_underflow = 1'b0;
      nb = $urandom_range(4, 34);
      for (int k = 0; k < nb; k++) begin
        bus.enable = ($urandom_range(0, 79) != 0);
        step(1, 0, 0);
        bus.enable = 1'b1;
        step(0, 0, 0);
      end
      rise = !rise;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
